// File: rtl/conv_pkg.sv
// Shared types and helpers for the conv/pool stream blocks.
// Default geometry matches the conv output of 96-65+1 samples.
package conv_pkg;

  localparam int SAMPLE_W = 16;
  localparam int LEN_DEF  = 32;
  localparam int POOL_DEF = 2;
  localparam int NUM_OUT  = (LEN_DEF + POOL_DEF - 1) / POOL_DEF;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic sample_t max_s(input sample_t a, input sample_t b);
    return (b > a) ? b : a;
  endfunction

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry valid/ready FIFO with registered not_full.
// not_full is derived from the next-state count so it never lags a push.
module stream_fifo2 #(
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid,
  input  logic [WIDTH-1:0] wr_data,
  output logic             not_full,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  input  logic             rd_ready
);

  logic [WIDTH-1:0] mem0, mem1;
  logic             wr_ptr, rd_ptr;
  logic [1:0]       count, count_nxt;
  logic             push, pop;

  assign push = wr_valid & (count != 2'd2);
  assign pop  = rd_ready & (count != 2'd0);

  always_comb begin
    count_nxt = count;
    if (push & ~pop) count_nxt = count + 2'd1;
    if (pop & ~push) count_nxt = count - 2'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem0     <= '0;
      mem1     <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
      not_full <= 1'b0;
    end else begin
      if (push) begin
        if (wr_ptr) mem1 <= wr_data;
        else        mem0 <= wr_data;
        wr_ptr <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count    <= count_nxt;
      not_full <= (count_nxt != 2'd2);
    end
  end

  assign rd_data  = rd_ptr ? mem1 : mem0;
  assign rd_valid = (count != 2'd0);

endmodule

// File: rtl/maxpool_stream.sv
// Non-overlapping 1-D signed max-pool over fixed-length vectors.
// The final window of a vector may be partial and is flushed at vector end.
module maxpool_stream
  import conv_pkg::*;
#(
  parameter int T      = SAMPLE_W,
  parameter int LEN_IN = LEN_DEF,
  parameter int POOL   = POOL_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic signed [T-1:0] x_data,
  input  logic                x_valid,
  output logic                x_ready,
  output logic signed [T-1:0] y_data,
  output logic                y_valid,
  input  logic                y_ready,
  output logic                y_last
);

  localparam int WC = cnt_w(POOL);
  localparam int IC = cnt_w(LEN_IN);

  logic [WC-1:0]       win_cnt;
  logic [IC-1:0]       in_cnt;
  logic signed [T-1:0] run_max;
  logic signed [T-1:0] cand;
  logic                acc, vec_end, close;
  logic                not_full, rd_valid;
  logic [T:0]          rd_data;

  assign acc     = x_valid & x_ready;
  assign vec_end = (in_cnt == IC'(LEN_IN - 1));
  assign close   = (win_cnt == WC'(POOL - 1)) | vec_end;

  // First sample of a window replaces the running max outright
  always_comb begin
    cand = x_data;
    if (win_cnt != '0 && run_max > x_data) cand = run_max;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_cnt <= '0;
      in_cnt  <= '0;
      run_max <= '0;
    end else if (acc) begin
      run_max <= cand;
      win_cnt <= close ? '0 : win_cnt + WC'(1);
      in_cnt  <= vec_end ? '0 : in_cnt + IC'(1);
    end
  end

  stream_fifo2 #(
    .WIDTH(T + 1)
  ) u_fifo (
    .clk      (clk),
    .rst      (reset),
    .wr_valid (acc & close),
    .wr_data  ({vec_end, cand}),
    .not_full (not_full),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_ready (y_ready)
  );

  assign x_ready = not_full;
  assign y_valid = rd_valid;
  assign y_data  = rd_valid ? rd_data[T-1:0] : '0;
  assign y_last  = rd_valid & rd_data[T];

endmodule

// File: tb/tb_maxpool_stream.sv
// Scoreboard bench: a short-vector instance and a default-geometry instance.
// Expected outputs are queued at issue time and popped on each y handshake.
module tb_maxpool_stream;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic signed [15:0] x5d, y5d, x32d, y32d;
  logic x5v, x5r, y5v, y5r, y5l;
  logic x32v, x32r, y32v, y32r, y32l;

  maxpool_stream #(.T(16), .LEN_IN(5), .POOL(2)) u5 (
    .clk(clk), .reset(reset),
    .x_data(x5d), .x_valid(x5v), .x_ready(x5r),
    .y_data(y5d), .y_valid(y5v), .y_ready(y5r), .y_last(y5l)
  );

  maxpool_stream u32 (
    .clk(clk), .reset(reset),
    .x_data(x32d), .x_valid(x32v), .x_ready(x32r),
    .y_data(y32d), .y_valid(y32v), .y_ready(y32r), .y_last(y32l)
  );

  int checks = 0;
  int passes = 0;
  int stalls5 = 0;
  bit rnd = 0;
  bit done3 = 0;
  logic [16:0] q5[$];
  logic [16:0] q32[$];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp)
      $display("FAIL %s: got %h want %h", nm, act, exp);
    else
      passes++;
  endtask

  // Monitor: a handshake is committed at the following rising edge
  always @(negedge clk) begin
    if (!reset) begin
      if (y5v === 1'b1 && y5r === 1'b1) begin
        if (q5.size() == 0) check("u5_unexpected", {15'd0, y5l, y5d}, 32'hdead);
        else check("u5_out", {15'd0, y5l, y5d}, {15'd0, q5.pop_front()});
      end
      if (y32v === 1'b1 && y32r === 1'b1) begin
        if (q32.size() == 0) check("u32_unexpected", {15'd0, y32l, y32d}, 32'hdead);
        else check("u32_out", {15'd0, y32l, y32d}, {15'd0, q32.pop_front()});
      end
    end
  end

  task automatic send5(input int v);
    int n = 0;
    x5v = 1'b1;
    x5d = 16'(v);
    @(negedge clk);
    while (!x5r && n < 300) begin n++; @(negedge clk); end
    if (n > 0) stalls5++;
    if (n >= 300) check("u5_send_timeout", 32'(n), 32'd0);
    @(posedge clk); #1;
    x5v = 1'b0;
  endtask

  task automatic send32(input int v);
    int n = 0;
    if (rnd) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    x32v = 1'b1;
    x32d = 16'(v);
    @(negedge clk);
    while (!x32r && n < 300) begin n++; @(negedge clk); end
    if (n >= 300) check("u32_send_timeout", 32'(n), 32'd0);
    @(posedge clk); #1;
    x32v = 1'b0;
  endtask

  task automatic drain(input string nm);
    int k = 0;
    while ((q5.size() != 0 || q32.size() != 0) && k < 600) begin
      k++; @(posedge clk);
    end
    repeat (3) @(posedge clk);
    #1;
    check(nm, 32'(q5.size() + q32.size()), 32'd0);
  endtask

  function automatic logic [16:0] ent(input logic last, input int v);
    logic [15:0] d;
    d = 16'(v);
    return {last, d};
  endfunction

  initial begin
    int ext[6];
    logic signed [15:0] v[32];
    logic signed [15:0] m;
    x5v = 0; x5d = 0; y5r = 1;
    x32v = 0; x32d = 0; y32r = 1;

    // reset state
    #1;
    check("rst_x_ready", {31'd0, x5r}, 32'd0);
    check("rst_y_valid", {31'd0, y5v}, 32'd0);
    check("rst_y_last", {31'd0, y32l}, 32'd0);
    check("rst_y_data", {16'd0, y32d}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("x_ready_after_rst", {30'd0, x5r, x32r}, 32'd3);

    // 1: short vector with partial tail window
    q5.push_back(ent(0, 7));
    q5.push_back(ent(0, -2));
    q5.push_back(ent(1, 4));
    send5(3); send5(7); send5(-2); send5(-9); send5(4);
    drain("t1_drain");
    check("t1_no_stall", 32'(stalls5), 32'd0);

    // 2: ramp, two vectors
    for (int r = 0; r < 2; r++) begin
      for (int w = 0; w < 16; w++) q32.push_back(ent(w == 15, 2 * w + 1));
      for (int i = 0; i < 32; i++) send32(i);
    end
    drain("t2_drain");

    // 3: downstream stall mid-vector
    for (int w = 0; w < 16; w++) q32.push_back(ent(w == 15, 2 * w + 1));
    y32r = 1'b0;
    fork
      begin
        for (int i = 0; i < 32; i++) send32(i);
        done3 = 1'b1;
      end
    join_none
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("t3_x_ready_low", {31'd0, x32r}, 32'd0);
    check("t3_y_valid", {31'd0, y32v}, 32'd1);
    check("t3_head", {15'd0, y32l, y32d}, 32'd1);
    repeat (2) @(negedge clk);
    check("t3_head_stable", {15'd0, y32l, y32d}, 32'd1);
    @(posedge clk); #1;
    y32r = 1'b1;
    for (int k = 0; k < 400 && !done3; k++) @(posedge clk);
    #2;
    check("t3_done", {31'd0, done3}, 32'd1);
    drain("t3_drain");

    // 4: signed extremes, rest of vector zeros
    ext = '{-32768, -32768, -1, -32768, 32767, 0};
    q32.push_back(ent(0, -32768));
    q32.push_back(ent(0, -1));
    q32.push_back(ent(0, 32767));
    for (int w = 3; w < 16; w++) q32.push_back(ent(w == 15, 0));
    for (int i = 0; i < 6; i++) send32(ext[i]);
    for (int i = 6; i < 32; i++) send32(0);
    drain("t4_drain");

    // 5: reset mid-window with an output queued
    y5r = 1'b0;
    send5(3); send5(7); send5(100);
    @(negedge clk);
    check("t5_queued", {31'd0, y5v}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("t5_y_valid_async", {31'd0, y5v}, 32'd0);
    check("t5_x_ready_rst", {31'd0, x5r}, 32'd0);
    q5.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    y5r = 1'b1;
    q5.push_back(ent(0, 6));
    q5.push_back(ent(0, 2));
    q5.push_back(ent(1, 3));
    send5(5); send5(6); send5(1); send5(2); send5(3);
    drain("t5_drain");

    // 6: random data with random x gaps and y_ready toggling
    rnd = 1'b1;
    fork
      while (rnd) begin
        @(posedge clk); #1;
        y32r = 1'($urandom_range(0, 1));
      end
    join_none
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 32; i++) v[i] = 16'($urandom);
      for (int w = 0; w < 16; w++) begin
        m = ($signed(v[2*w+1]) > $signed(v[2*w])) ? v[2*w+1] : v[2*w];
        q32.push_back(ent(w == 15, int'(m)));
      end
      for (int i = 0; i < 32; i++) send32(int'(v[i]));
    end
    rnd = 1'b0;
    @(posedge clk); #2;
    y32r = 1'b1;
    drain("t6_drain");
    check("t6_no_x", {30'd0, ^{y32v, y32l, y32d, x32r} === 1'bx, 1'b0}, 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
